// File: rtl/id_ex_stage_if.sv
// ID-to-EX bundle: decoded fields from ID in, registered ALU-side fields out.
// master = ID/controller side, slave = the id_ex_stage register.
interface id_ex_stage_if #(
  parameter int W  = 32,
  parameter int RW = 5
);
  logic          id_valid;
  logic [1:0]    id_alu_op;
  logic [5:0]    id_funct;
  logic [4:0]    id_shamt;
  logic [W-1:0]  id_rs_data;
  logic [W-1:0]  id_rt_data;
  logic [W-1:0]  id_imm;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic          id_reg_dst;
  logic          id_alu_src;
  logic          id_reg_write;
  logic          id_mem_to_reg;
  logic          id_mem_read;
  logic          id_mem_write;

  logic [2:0]    ex_ctl;
  logic [W-1:0]  ex_a;
  logic [W-1:0]  ex_b;
  logic [4:0]    ex_shamt;
  logic [W-1:0]  ex_store_data;
  logic [RW-1:0] ex_dest;
  logic          ex_reg_write;
  logic          ex_mem_to_reg;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_valid;
  logic          ex_illegal;
  logic          hazard_stall;

  modport master (
    output id_valid, id_alu_op, id_funct, id_shamt,
    output id_rs_data, id_rt_data, id_imm,
    output id_rs, id_rt, id_rd,
    output id_reg_dst, id_alu_src, id_reg_write,
    output id_mem_to_reg, id_mem_read, id_mem_write,
    input  ex_ctl, ex_a, ex_b, ex_shamt, ex_store_data,
    input  ex_dest, ex_reg_write, ex_mem_to_reg,
    input  ex_mem_read, ex_mem_write, ex_valid,
    input  ex_illegal, hazard_stall
  );

  modport slave (
    input  id_valid, id_alu_op, id_funct, id_shamt,
    input  id_rs_data, id_rt_data, id_imm,
    input  id_rs, id_rt, id_rd,
    input  id_reg_dst, id_alu_src, id_reg_write,
    input  id_mem_to_reg, id_mem_read, id_mem_write,
    output ex_ctl, ex_a, ex_b, ex_shamt, ex_store_data,
    output ex_dest, ex_reg_write, ex_mem_to_reg,
    output ex_mem_read, ex_mem_write, ex_valid,
    output ex_illegal, hazard_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX register: ALU ctl decode, EX/MEM + MEM/WB forwarding, load-use detect.
// Ports: clk, rst (sync, high), stall, flush, io (slave), exmem_*, memwb_*.
// Macro ID_EX_FORWARD_EN: forwarding muxes; otherwise stall on any RAW.
module id_ex_stage #(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  id_ex_stage_if.slave  io,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [W-1:0]  exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [W-1:0]  memwb_result
);

  typedef struct packed {
    logic          valid;
    logic [2:0]    ctl;
    logic          illegal;
    logic          alu_src;
    logic          reg_write;
    logic          mem_to_reg;
    logic          mem_read;
    logic          mem_write;
    logic [4:0]    shamt;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] dest;
    logic [W-1:0]  rs_data;
    logic [W-1:0]  rt_data;
    logic [W-1:0]  imm;
  } id_ex_t;

  id_ex_t     r;
  id_ex_t     d;
  logic [2:0] ctl_d;
  logic       ill_d;

  always_comb begin
    ctl_d = 3'b010;
    ill_d = 1'b0;
    unique case (io.id_alu_op)
      2'b00: ctl_d = 3'b010;
      2'b01: ctl_d = 3'b110;
      2'b10: begin
        unique case (io.id_funct)
          6'b100000: ctl_d = 3'b010;
          6'b100010: ctl_d = 3'b110;
          6'b100100: ctl_d = 3'b000;
          6'b100101: ctl_d = 3'b001;
          6'b101010: ctl_d = 3'b111;
          6'b000000: ctl_d = 3'b011;
          default:   ill_d = 1'b1;
        endcase
      end
      default: ill_d = 1'b1;
    endcase
  end

  // A bubble (id_valid=0) carries no controls; illegal ops never write.
  always_comb begin
    d            = '0;
    d.valid      = io.id_valid;
    d.ctl        = io.id_valid ? ctl_d : 3'b000;
    d.illegal    = io.id_valid & ill_d;
    d.alu_src    = io.id_valid & io.id_alu_src;
    d.reg_write  = io.id_valid & io.id_reg_write & ~ill_d;
    d.mem_to_reg = io.id_valid & io.id_mem_to_reg;
    d.mem_read   = io.id_valid & io.id_mem_read;
    d.mem_write  = io.id_valid & io.id_mem_write & ~ill_d;
    d.shamt      = io.id_shamt;
    d.rs         = io.id_rs;
    d.rt         = io.id_rt;
    d.dest       = io.id_reg_dst ? io.id_rd : io.id_rt;
    d.rs_data    = io.id_rs_data;
    d.rt_data    = io.id_rt_data;
    d.imm        = io.id_imm;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r <= '0;
    else if (flush)
      r <= '0;
    else if (!stall)
      r <= d;
  end

  logic [W-1:0] fwd_a;
  logic [W-1:0] fwd_b;
  logic         hz_src;

`ifdef ID_EX_FORWARD_EN
  // Later assignment wins: EX/MEM overrides MEM/WB.
  always_comb begin
    fwd_a = r.rs_data;
    if (memwb_reg_write && memwb_rd == r.rs && r.rs != '0)
      fwd_a = memwb_result;
    if (exmem_reg_write && exmem_rd == r.rs && r.rs != '0)
      fwd_a = exmem_result;
  end

  always_comb begin
    fwd_b = r.rt_data;
    if (memwb_reg_write && memwb_rd == r.rt && r.rt != '0)
      fwd_b = memwb_result;
    if (exmem_reg_write && exmem_rd == r.rt && r.rt != '0)
      fwd_b = exmem_result;
  end

  assign hz_src = r.mem_read;
`else
  // No bypass paths, so any producer in EX must stall its consumer.
  assign fwd_a  = r.rs_data;
  assign fwd_b  = r.rt_data;
  assign hz_src = r.mem_read | r.reg_write;

  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result};
`endif

  assign io.ex_ctl        = r.ctl;
  assign io.ex_a          = fwd_a;
  assign io.ex_b          = r.alu_src ? r.imm : fwd_b;
  assign io.ex_shamt      = r.shamt;
  assign io.ex_store_data = fwd_b;
  assign io.ex_dest       = r.dest;
  assign io.ex_reg_write  = r.reg_write;
  assign io.ex_mem_to_reg = r.mem_to_reg;
  assign io.ex_mem_read   = r.mem_read;
  assign io.ex_mem_write  = r.mem_write;
  assign io.ex_valid      = r.valid;
  assign io.ex_illegal    = r.illegal;

  assign io.hazard_stall = r.valid & hz_src & (r.dest != '0) &
                           (r.dest == io.id_rs | r.dest == io.id_rt);

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, directly upstream of the EX-stage ALU.
- Captures decoded operands and controls from ID, generates the ALU's 3-bit ctl from ALUOp/funct, and forwards results from EX/MEM and MEM/WB into the ALU a/b inputs.
- Also flags load-use hazards back to the ID stage.

Parameters:
- W, 32, datapath width (must match ALU width).
- RW, 5, register-index width.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all pipeline registers this cycle
- flush  in  1  load a bubble next cycle
- id_valid  in  1  ID holds a real instruction
- id_alu_op  in  2  00=add (lw/sw), 01=sub (beq), 10=R-type by funct, 11=reserved
- id_funct  in  6  instruction funct field
- id_shamt  in  5  shift amount
- id_rs_data, id_rt_data  in  W  register-file read data
- id_imm  in  W  sign-extended immediate
- id_rs, id_rt, id_rd  in  RW  register indices
- id_reg_dst, id_alu_src, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write  in  1 each  main-decoder controls
- exmem_reg_write  in  1, exmem_rd  in  RW, exmem_result  in  W  EX/MEM writeback info
- memwb_reg_write  in  1, memwb_rd  in  RW, memwb_result  in  W  MEM/WB writeback info
- ex_ctl  out  3  ALU ctl: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 SLL
- ex_a, ex_b  out  W  ALU operands
- ex_shamt  out  5  ALU shamt
- ex_store_data  out  W  forwarded rt value for sw
- ex_dest  out  RW  writeback register (rd if reg_dst else rt)
- ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_valid  out  1 each  registered controls
- ex_illegal  out  1  unsupported funct/ALUOp captured
- hazard_stall  out  1  load-use hazard request to the PC/IF-ID registers

Behaviour:
- Reset: every register clears to 0. Outputs are then ex_ctl=000, ex_a=ex_b=0, ex_dest=0, all controls 0, hazard_stall=0.
- Priority on each rising edge: rst > flush > stall > load.
  - flush: clear valid and all controls; data fields don't-care (cleared to 0).
  - stall: hold everything.
  - Otherwise capture all id_* inputs.
- Latency: one cycle from ID inputs to ex_* outputs.
- ctl decode happens in ID and is registered.
  - ALUOp 00 -> 010; 01 -> 110.
  - ALUOp 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, 000000 -> 011.
  - Any other funct or ALUOp 11 -> ctl 010, ex_illegal=1, registered reg_write/mem_write forced 0.
- id_valid=0 captures as a bubble: all controls 0.
- Forwarding is combinational from the registered rs/rt fields.
  - Source A value: exmem_result if exmem_reg_write, exmem_rd==rs and rs!=0; else memwb_result if the same MEM/WB match; else the registered rs data.
  - Source B value: same rule using rt.
  - EX/MEM wins when both stages match.
  - Register 0 is never forwarded.
- ex_a = forwarded A. For SLL (ctl 011) ex_a is don't-care, because the ALU shifts b.
- ex_b = registered imm if alu_src, else forwarded B.
- ex_store_data = forwarded B always.
- hazard_stall (combinational) = ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt).
  - The controller is expected to respond with flush=1 and hold IF/ID.
  - flush and stall together: flush wins.
- rst mid-stall: registers clear; stall is ignored that cycle.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding muxes exactly as above.
- Undefined:
  - Muxes removed; ex_a = registered rs data; ex_b = imm or registered rt data; ex_store_data = registered rt data.
  - exmem_*/memwb_* inputs unused.
  - hazard_stall additionally asserts for any RAW on an ex_dest with ex_reg_write (not just loads).

Test Plan:
- Reset: rst=1 for 2 cycles with random ID inputs -> all outputs 0, hazard_stall=0.
- R-type decode: ALUOp=10 with funct 100010, then 101010, then 000000 (shamt=5) -> ex_ctl 110, 111, then 011 with ex_shamt=5. Funct 001111 -> ex_illegal=1, ex_reg_write=0.
- Forward priority: rs=3, id_rs_data=0x11; EX/MEM writes r3=0xAA; MEM/WB writes r3=0xBB.
  - Both match -> ex_a=0xAA.
  - Drop exmem_reg_write -> ex_a=0xBB.
  - rs=0 with both matching -> ex_a=0.
- ALUSrc: alu_src=1, imm=0xFFFFFFFC, rt forwarded 0x55 -> ex_b=0xFFFFFFFC, ex_store_data=0x55.
- Load-use: lw r4 in EX (mem_read=1, dest=4); ID has id_rt=4 -> hazard_stall=1. Assert flush -> next cycle ex_valid=0, all controls 0, hazard_stall=0.
- Stall/flush: stall=1 for 3 cycles -> outputs frozen. stall=1 with flush=1 -> bubble loaded.
